// File: rtl/scc_wave_pkg.sv
// Shared constants, register decode types and address decoder for scc_wave_engine.
package scc_wave_pkg;

    localparam int unsigned MAX_CHANNELS = 8;
    localparam int unsigned CH_W         = 3;
    localparam int unsigned SAMPLE_W     = 8;
    localparam int unsigned VOL_W        = 4;
    localparam int unsigned FREQ_W       = 12;
    localparam int unsigned PHASE_W      = 5;
    localparam int unsigned OUT_W        = 16;
    localparam int unsigned WAVE_BYTES   = MAX_CHANNELS * (2 ** PHASE_W);

    localparam logic [8:0] WAVE_BASE = 9'h000;
    localparam logic [8:0] FREQ_BASE = 9'h100;
    localparam logic [8:0] VOL_BASE  = 9'h110;
    localparam logic [8:0] MASK_ADDR = 9'h118;
    localparam logic [8:0] ID_ADDR   = 9'h119;

    // Below this reload value the channel timer is frozen.
    localparam logic [FREQ_W-1:0] FREQ_MIN = 12'd9;

    typedef enum logic [2:0] {
        RegNone,
        RegWave,
        RegFreqLo,
        RegFreqHi,
        RegVol,
        RegMask,
        RegId
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e             sel;
        logic [CH_W-1:0]      ch;
        logic [PHASE_W-1:0]   idx;
    } reg_dec_t;

    // Map a bus address to a register class; channels >= channels decode as RegNone.
    function automatic reg_dec_t decode(input logic [8:0] addr, input int unsigned channels);
        reg_dec_t dec;
        dec.sel = RegNone;
        dec.ch  = addr[7:5];
        dec.idx = addr[4:0];
        if (addr[8] == WAVE_BASE[8]) begin
            if (32'(addr[7:5]) < channels) dec.sel = RegWave;
        end else if (addr[8:4] == FREQ_BASE[8:4]) begin
            dec.ch = addr[3:1];
            if (32'(addr[3:1]) < channels) dec.sel = addr[0] ? RegFreqHi : RegFreqLo;
        end else if (addr[8:3] == VOL_BASE[8:3]) begin
            dec.ch = addr[2:0];
            if (32'(addr[2:0]) < channels) dec.sel = RegVol;
        end else if (addr == MASK_ADDR) begin
            dec.sel = RegMask;
        end else if (addr == ID_ADDR) begin
            dec.sel = RegId;
        end
        return dec;
    endfunction

endpackage

// File: rtl/scc_wave_channel_timer.sv
// Per-channel phase timer: 12-bit down-counter that steps a 5-bit phase every freq+1 clocks.
module scc_wave_channel_timer
    import scc_wave_pkg::*;
(
    input  logic               clk,
    input  logic               nreset,
    input  logic [FREQ_W-1:0]  freq_i,
    input  logic               freeze_i,
    input  logic               phase_rst_i,
    input  logic [FREQ_W-1:0]  reload_val_i,
    output logic [PHASE_W-1:0] phase_o
);

    logic [FREQ_W-1:0]  count_q, count_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    // Next-state: phase reset wins over freeze, freeze holds everything.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (phase_rst_i) begin
            count_d = reload_val_i;
            phase_d = '0;
        end else if (!freeze_i) begin
            if (count_q == '0) begin
                count_d = freq_i;
                phase_d = phase_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter and phase state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
            phase_q <= '0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/scc_wave_engine.sv
// N-channel wavetable sound engine: wave RAM, register file, read mux and time-multiplexed mixer.
// Optional feature: define SCC_WAVE_PHASE_RESET_EN to restart a channel's phase on freq writes.
module scc_wave_engine
    import scc_wave_pkg::*;
#(
    parameter int unsigned CHANNELS = 5
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             wrreq,
    input  logic             rdreq,
    input  logic [8:0]       address,
    input  logic [7:0]       wrdata,
    output logic [7:0]       rddata,
    output logic [OUT_W-1:0] left_out,
    output logic             frame_strobe
);

    localparam logic [MAX_CHANNELS-1:0] CH_MASK = MAX_CHANNELS'((32'd1 << CHANNELS) - 32'd1);
    localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(CHANNELS - 1);

    // Storage is sized for MAX_CHANNELS; entries of absent channels are never written.
    logic [SAMPLE_W-1:0]     wave_q [WAVE_BYTES];
    logic [FREQ_W-1:0]       freq_q [MAX_CHANNELS];
    logic [VOL_W-1:0]        vol_q  [MAX_CHANNELS];
    logic [MAX_CHANNELS-1:0] mask_q;
    logic [7:0]              rddata_q, rd_val;
    logic [PHASE_W-1:0]      phase  [MAX_CHANNELS];

    reg_dec_t          dec;
    logic              freq_we;
    logic [FREQ_W-1:0] freq_wr_val;
    logic [MAX_CHANNELS-1:0] phase_rst;

    assign dec     = decode(address, CHANNELS);
    assign freq_we = wrreq && (dec.sel == RegFreqLo || dec.sel == RegFreqHi);

    // Merge the written byte into the channel's current 12-bit freq.
    always_comb begin
        freq_wr_val = freq_q[dec.ch];
        if (dec.sel == RegFreqLo) freq_wr_val[7:0] = wrdata;
        else                      freq_wr_val[11:8] = wrdata[3:0];
    end

`ifdef SCC_WAVE_PHASE_RESET_EN
    // Strobe the phase reset of the channel whose freq is being written.
    always_comb begin
        phase_rst = '0;
        if (freq_we) phase_rst[dec.ch] = 1'b1;
    end
`else
    assign phase_rst = '0;
`endif

    for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_ch
        if (c < CHANNELS) begin : g_timer
            scc_wave_channel_timer u_timer (
                .clk          (clk),
                .nreset       (nreset),
                .freq_i       (freq_q[c]),
                .freeze_i     (freq_q[c] < FREQ_MIN),
                .phase_rst_i  (phase_rst[c]),
                .reload_val_i (freq_wr_val),
                .phase_o      (phase[c])
            );
        end else begin : g_absent
            assign phase[c] = '0;
        end
    end

    // Register file writes; undecoded or out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < WAVE_BYTES; i++) wave_q[i] <= '0;
            for (int c = 0; c < MAX_CHANNELS; c++) begin
                freq_q[c] <= '0;
                vol_q[c]  <= '0;
            end
            mask_q <= '0;
        end else begin
            if (freq_we) freq_q[dec.ch] <= freq_wr_val;
            if (wrreq) begin
                unique case (dec.sel)
                    RegWave: wave_q[{dec.ch, dec.idx}] <= wrdata;
                    RegVol:  vol_q[dec.ch] <= wrdata[VOL_W-1:0];
                    RegMask: mask_q <= wrdata & CH_MASK;
                    default: ;
                endcase
            end
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = 8'hFF;
        case (dec.sel)
            RegWave:   rd_val = wave_q[{dec.ch, dec.idx}];
            RegFreqLo: rd_val = freq_q[dec.ch][7:0];
            RegFreqHi: rd_val = {4'h0, freq_q[dec.ch][11:8]};
            RegVol:    rd_val = {4'h0, vol_q[dec.ch]};
            RegMask:   rd_val = mask_q;
            RegId:     rd_val = 8'(CHANNELS);
            default:   rd_val = 8'hFF;
        endcase
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)    rddata_q <= '0;
        else if (rdreq) rddata_q <= rd_val;
    end

    assign rddata = rddata_q;

    logic [CH_W-1:0]            slot_q;
    logic signed [OUT_W-1:0]    acc_q, left_q, prod, sum;
    logic                       strobe_q;
    logic [SAMPLE_W-1:0]        sample;
    logic [OUT_W-1:0]           sample_ext, vol_ext;

    // Current slot's contribution: signed sample times unsigned volume, zero when masked.
    always_comb begin
        sample     = wave_q[{slot_q, phase[slot_q]}];
        sample_ext = {{(OUT_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        vol_ext    = {{(OUT_W - VOL_W){1'b0}}, vol_q[slot_q]};
        prod       = mask_q[slot_q] ? $signed(sample_ext) * $signed(vol_ext) : '0;
        sum        = acc_q + prod;
    end

    // Slot sequencer and accumulator; the last slot publishes the frame and clears the sum.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_q   <= '0;
            acc_q    <= '0;
            left_q   <= '0;
            strobe_q <= 1'b0;
        end else if (slot_q == LAST_SLOT) begin
            slot_q   <= '0;
            acc_q    <= '0;
            left_q   <= sum;
            strobe_q <= 1'b1;
        end else begin
            slot_q   <= slot_q + 1'b1;
            acc_q    <= sum;
            strobe_q <= 1'b0;
        end
    end

    assign left_out     = left_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_scc_wave_engine.sv
// Directed bench for scc_wave_engine: a 5-channel and an 8-channel instance side by side.
module tb_scc_wave_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               nreset;
    logic               wrreq5, wrreq8, rdreq;
    logic [8:0]         address;
    logic [7:0]         wrdata;
    logic [7:0]         rddata5, rddata8;
    logic signed [15:0] left5, left8;
    logic               strobe5, strobe8;

    int n_cmp = 0;
    int n_bad = 0;

    scc_wave_engine #(.CHANNELS(5)) u_dut5 (
        .clk          (clk),
        .nreset       (nreset),
        .wrreq        (wrreq5),
        .rdreq        (rdreq),
        .address      (address),
        .wrdata       (wrdata),
        .rddata       (rddata5),
        .left_out     (left5),
        .frame_strobe (strobe5)
    );

    scc_wave_engine #(.CHANNELS(8)) u_dut8 (
        .clk          (clk),
        .nreset       (nreset),
        .wrreq        (wrreq8),
        .rdreq        (rdreq),
        .address      (address),
        .wrdata       (wrdata),
        .rddata       (rddata8),
        .left_out     (left8),
        .frame_strobe (strobe8)
    );

    task automatic wr(input logic [8:0] a, input logic [7:0] d, input bit big);
        @(negedge clk);
        address = a;
        wrdata  = d;
        if (big) wrreq8 = 1'b1;
        else     wrreq5 = 1'b1;
        @(negedge clk);
        wrreq5 = 1'b0;
        wrreq8 = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a, input bit big, output logic [7:0] d);
        @(negedge clk);
        address = a;
        rdreq   = 1'b1;
        @(negedge clk);
        rdreq = 1'b0;
        d = big ? rddata8 : rddata5;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        nreset = 1'b0;
        wrreq5 = 1'b0; wrreq8 = 1'b0; rdreq = 1'b0;
        address = 9'h000; wrdata = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wrreq5 = i[0]; wrreq8 = i[0]; rdreq = ~i[0];
        end
        @(negedge clk);
        wrreq5 = 1'b0; wrreq8 = 1'b0; rdreq = 1'b0;
        n_cmp++;
        if ({rddata5, rddata8} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_rddata: got %h/%h want 00/00", rddata5, rddata8);
        end
        n_cmp++;
        if (left5 !== 16'sd0 || left8 !== 16'sd0) begin
            n_bad++; $display("FAIL reset_left: got %0d/%0d want 0/0", left5, left8);
        end
        n_cmp++;
        if ({strobe5, strobe8} !== 2'b00) begin
            n_bad++; $display("FAIL reset_strobe: got %b%b want 00", strobe5, strobe8);
        end
        nreset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (strobe5 !== (k == 5) || strobe8 !== (k == 8)) begin
                n_bad++;
                $display("FAIL first_strobe clk %0d: got %b%b want %b%b", k, strobe5, strobe8,
                         k == 5, k == 8);
            end
        end
        rd(9'h119, 1'b0, d);
        n_cmp++;
        if (d !== 8'h05) begin n_bad++; $display("FAIL id5: got %h want 05", d); end
        rd(9'h119, 1'b1, d);
        n_cmp++;
        if (d !== 8'h08) begin n_bad++; $display("FAIL id8: got %h want 08", d); end
        rd(9'h000, 1'b0, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL wave_after_reset: got %h want 00", d); end
    endtask

    task automatic test_single_tone();
        int t;
        int strobes;
        for (int i = 0; i < 32; i++) wr(9'(i), (i < 16) ? 8'h40 : 8'hC0, 1'b0);
        wr(9'h110, 8'h0F, 1'b0);
        wr(9'h118, 8'h01, 1'b0);
        wr(9'h100, 8'h09, 1'b0);
        t = 0;
        while (left5 !== -16'sd960 && t < 400) begin @(negedge clk); t++; end
        n_cmp++;
        if (left5 !== -16'sd960) begin n_bad++; $display("FAIL tone_neg: got %0d want -960", left5); end
        t = 0;
        while (left5 !== 16'sd960 && t < 400) begin @(negedge clk); t++; end
        n_cmp++;
        if (left5 !== 16'sd960) begin n_bad++; $display("FAIL tone_pos: got %0d want 960", left5); end
        t = 0;
        while (left5 === 16'sd960 && t < 400) begin @(negedge clk); t++; end
        n_cmp++;
        if (t !== 160 || left5 !== -16'sd960) begin
            n_bad++; $display("FAIL tone_half_hi: got %0d clk to %0d want 160 to -960", t, left5);
        end
        t = 0;
        while (left5 === -16'sd960 && t < 400) begin @(negedge clk); t++; end
        n_cmp++;
        if (t !== 160 || left5 !== 16'sd960) begin
            n_bad++; $display("FAIL tone_half_lo: got %0d clk to %0d want 160 to 960", t, left5);
        end
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (strobe5) strobes++;
        end
        n_cmp++;
        if (strobes !== 20) begin n_bad++; $display("FAIL tone_strobes: got %0d want 20", strobes); end
    endtask

    task automatic test_freeze();
        logic signed [15:0] v0;
        int changes;
        wr(9'h100, 8'h08, 1'b0);
        idle(20);
        v0 = left5;
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (left5 !== v0) changes++;
        end
        n_cmp++;
        if (changes !== 0) begin n_bad++; $display("FAIL freeze_changes: got %0d want 0", changes); end
        n_cmp++;
        if (v0 !== 16'sd960 && v0 !== -16'sd960) begin
            n_bad++; $display("FAIL freeze_level: got %0d want +-960", v0);
        end
    endtask

    task automatic test_phase_reset();
        logic signed [15:0] v, exp;
        int t;
        for (int i = 0; i < 32; i++) wr(9'(i), 8'(i + 1), 1'b0);
        wr(9'h110, 8'h01, 1'b0);
        wr(9'h100, 8'h09, 1'b0);
        t = 0;
        while (left5 !== 16'sd11 && t < 800) begin @(negedge clk); t++; end
        wr(9'h100, 8'h08, 1'b0);
        idle(20);
        v = left5;
        n_cmp++;
        if (v < 16'sd2 || v > 16'sd32) begin
            n_bad++; $display("FAIL phase_setup: got %0d want 2..32", v);
        end
        wr(9'h100, 8'h08, 1'b0);
        idle(20);
`ifdef SCC_WAVE_PHASE_RESET_EN
        exp = 16'sd1;
`else
        exp = v;
`endif
        n_cmp++;
        if (left5 !== exp) begin n_bad++; $display("FAIL phase_reset: got %0d want %0d", left5, exp); end
    endtask

    task automatic test_bounds();
        logic [7:0] d;
        @(negedge clk);
        address = 9'h111; wrdata = 8'h07; wrreq5 = 1'b1; rdreq = 1'b1;
        @(negedge clk);
        wrreq5 = 1'b0; rdreq = 1'b0;
        n_cmp++;
        if (rddata5 !== 8'h00) begin n_bad++; $display("FAIL wr_rd_same: got %h want 00", rddata5); end
        rd(9'h111, 1'b0, d);
        n_cmp++;
        if (d !== 8'h07) begin n_bad++; $display("FAIL vol_readback: got %h want 07", d); end
        wr(9'h0A0, 8'h55, 1'b0);
        wr(9'h10A, 8'h55, 1'b0);
        rd(9'h0A0, 1'b0, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL wave_oob: got %h want FF", d); end
        rd(9'h10A, 1'b0, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL freq_oob: got %h want FF", d); end
        rd(9'h11A, 1'b0, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL unmapped: got %h want FF", d); end
        wr(9'h118, 8'hFF, 1'b0);
        rd(9'h118, 1'b0, d);
        n_cmp++;
        if (d !== 8'h1F) begin n_bad++; $display("FAIL mask5: got %h want 1F", d); end
        wr(9'h101, 8'hAB, 1'b0);
        rd(9'h101, 1'b0, d);
        n_cmp++;
        if (d !== 8'h0B) begin n_bad++; $display("FAIL freq_hi: got %h want 0B", d); end
        rd(9'h100, 1'b0, d);
        n_cmp++;
        if (d !== 8'h08) begin n_bad++; $display("FAIL freq_lo: got %h want 08", d); end
    endtask

    task automatic test_full_mix();
        logic [7:0] d;
        int strobes;
        for (int i = 0; i < 256; i++) wr(9'(i), 8'h7F, 1'b1);
        for (int c = 0; c < 8; c++) wr(9'h110 + 9'(c), 8'h0F, 1'b1);
        wr(9'h118, 8'hFF, 1'b1);
        idle(20);
        n_cmp++;
        if (left8 !== 16'sd15240) begin n_bad++; $display("FAIL mix_pos: got %0d want 15240", left8); end
        rd(9'h118, 1'b1, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL mask8: got %h want FF", d); end
        for (int i = 0; i < 256; i++) wr(9'(i), 8'h80, 1'b1);
        idle(20);
        n_cmp++;
        if (left8 !== -16'sd15360) begin
            n_bad++; $display("FAIL mix_neg: got %0d want -15360", left8);
        end
        strobes = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (strobe8) strobes++;
        end
        n_cmp++;
        if (strobes !== 10) begin n_bad++; $display("FAIL mix_strobes: got %0d want 10", strobes); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        n_cmp++;
        if (left8 !== 16'sd0 || strobe8 !== 1'b0 || rddata8 !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: got %0d/%b/%h want 0/0/00", left8, strobe8, rddata8);
        end
        @(negedge clk);
        nreset = 1'b1;
        idle(20);
        n_cmp++;
        if (left8 !== 16'sd0) begin n_bad++; $display("FAIL post_reset_mix: got %0d want 0", left8); end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_freeze();
        test_phase_reset();
        test_bounds();
        test_full_mix();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scc_wave_engine.md
# scc_wave_engine

Parametrised N-channel wavetable sound engine. It is the successor to the fixed SCC core: channel count is a parameter, the register map is flat, every channel has its own 32-byte waveform, and the block produces one mixed signed output per mixing frame. It sits behind the cartridge bus decoder, which supplies single-cycle `wrreq`/`rdreq` strobes. `left_out` feeds the DAC/PWM stage.

## Interface
Parameters
- `CHANNELS`, default 5: number of voices, legal range 1..8.

Ports
- `clk`  in  1: system clock.
- `nreset`  in  1: asynchronous active-low reset.
- `wrreq`  in  1: single-cycle write strobe.
- `rdreq`  in  1: single-cycle read strobe.
- `address`  in  9: register address.
- `wrdata`  in  8: write data.
- `rddata`  out  8: read data. Registered and held until the next `rdreq`.
- `left_out`  out  16: signed mixed sample.
- `frame_strobe`  out  1: one-cycle pulse in the cycle `left_out` changes.

## Operation
Register map (channel `c` < CHANNELS):
- 0x000–0x0FF wave RAM: byte `c*32+i` is signed sample `i` of channel `c`.
- 0x100+2c: freq[7:0] of channel `c`.
- 0x101+2c: freq[11:8] in wrdata[3:0]; upper bits ignored, read as 0.
- 0x110+c: volume in [3:0].
- 0x118: enable mask, bit `c` enables channel `c`.
- 0x119: read-only; reads CHANNELS.

Unmapped addresses and addresses belonging to channels ≥ CHANNELS:
- Writes are ignored.
- Reads return 0xFF.
- Mask bits ≥ CHANNELS read 0.

Per-channel timer, running every clock for every channel in parallel:
- 12-bit down-counter. On reaching 0 it reloads `freq` and the 5-bit phase advances (wraps 31→0).
- The phase step period is freq+1 clocks.
- freq < 9: counter and phase frozen (SCC behaviour).
- Disabled channels keep running; only their mix contribution is 0.

Mixer (time-multiplexed):
- Slot counter 0..CHANNELS-1 advances every clock and wraps.
- In slot `c`: product = wave[c][phase_c] (signed 8) × {0,volume_c} (signed 5) → signed 12. The product is forced to 0 if the channel is disabled.
- Products are sign-extended to 16 bits and accumulated.
- In the clock after slot CHANNELS-1, `left_out` takes the accumulator value, `frame_strobe` pulses and the accumulator restarts. No saturation is needed: the maximum magnitude is 8×1920 = 15360.

Register writes:
- A write takes effect at the clock edge of `wrreq`.
- A wave write to the sample being read in that same cycle: the mixer uses the old value.
- Simultaneous `wrreq` and `rdreq`: both are performed; the read returns the pre-write value.

## Timing
- Reset values:
  - All wave bytes, freq, volume and mask: 0.
  - Counters and phases: 0; slot: 0.
  - `rddata`: 0x00; `left_out`: 0; `frame_strobe`: 0.
- Read latency: `rddata` is valid one clock after `rdreq`.
- Frame period: CHANNELS clocks. The first `frame_strobe` comes CHANNELS clocks after reset release.
- Write-to-output latency: ≤ 2·CHANNELS+1 clocks.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial accumulation is discarded.
- CHANNELS=1: slot counter is constant 0 and `frame_strobe` is high every clock after the first.

## Configuration
- `SCC_WAVE_PHASE_RESET_EN` defined: any write to a channel's freq register (low or high byte) clears that channel's phase to 0 and reloads its counter with the new freq in the same clock.
- Not defined: freq writes change only the reload value. The current count and phase continue undisturbed.

## Structure
- Package `scc_wave_pkg`: register base constants (WAVE_BASE, FREQ_BASE, VOL_BASE, MASK_ADDR, ID_ADDR), MAX_CHANNELS=8, and width constants (SAMPLE_W=8, VOL_W=4, FREQ_W=12, PHASE_W=5, OUT_W=16).
- Sub-module `scc_wave_channel_timer`: one down-counter plus phase register with freeze and phase-reset inputs. It is instantiated CHANNELS times in a generate loop.
- Wave RAM, register file, read mux and mixer live in the top module.

## Test plan
- **Reset:** hold `nreset`=0 with toggling strobes → all outputs 0. Read 0x119 after reset release → `rddata`=0x05 for CHANNELS=5.
- **Single tone:**
  - Setup: ch0 wave = +64 at i=0..15 and −64 at i=16..31; volume 15; freq 9; mask 0x01.
  - Required: `left_out` alternates +960 / −960 with a period of 320 clocks, and `frame_strobe` pulses every 5 clocks.
- **Freeze:** ch0 running, then write freq 8 → the phase stops advancing and `left_out` stays constant across 1000 clocks.
- **Full mix, CHANNELS=8:**
  - Setup: all waves +127, all volumes 15, mask 0xFF.
  - Required: `left_out`=15240. With all waves −128 instead: `left_out`=−15360.
- **Bounds:**
  - CHANNELS=5: write 0x0A0 and 0x10A, then read them back → 0xFF. A mask write of 0xFF reads back 0x1F.
  - Read freq high after writing 0xAB → 0x0B.
- **Phase reset:** mid-period, write freq low of ch0.
  - With `SCC_WAVE_PHASE_RESET_EN`: the phase is 0 on the next clock.
  - Without it: the phase is unchanged.
